// File: rtl/dct_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dct_mac_sequencer
// Brief  : Sequences x/C pairs through an external Booth multiplier and sums
//          NTAP products per DCT output. DCT_MAC_SAT_EN clamps out_y to int16.
// Rev    : 1.0  initial release
// ============================================================================
module dct_mac_sequencer #(
   parameter int DW   = 8,
   parameter int NTAP = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_x,
   input  logic [DW-1:0]     in_c,
   output logic              mul_clr,
   output logic              mul_start,
   output logic [DW-1:0]     mul_m,
   output logic [DW-1:0]     mul_q,
   input  logic              mul_done,
   input  logic [2*DW-1:0]   mul_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*DW+2:0]   out_y
);

   localparam int AW = 2*DW+3;
   localparam int CW = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam logic [CW-1:0] LAST_TAP = CW'(NTAP-1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      ACC   = 3'd4,
      OUT   = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [DW-1:0]         x_q, x_d;
   logic [DW-1:0]         c_q, c_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic signed [AW-1:0]  prod_ext;

   assign prod_ext = {{3{mul_prod[2*DW-1]}}, mul_prod};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         c_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      c_d       = c_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      mul_clr   = 1'b0;
      mul_start = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               x_d     = in_x;
               c_d     = in_c;
               state_d = CLR;
            end
         end
         CLR: begin
            mul_clr = 1'b1;
            state_d = START;
         end
         START: begin
            mul_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            if (mul_done) state_d = ACC;
         end
         ACC: begin
            // First tap overwrites so leftovers can never leak into a new output
            acc_d   = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == LAST_TAP) ? OUT : IDLE;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mul_m = c_q;
   assign mul_q = x_q;

`ifdef DCT_MAC_SAT_EN
   localparam logic signed [AW-1:0] SAT_HI = AW'(32767);
   localparam logic signed [AW-1:0] SAT_LO = AW'(-32768);

   always_comb begin
      if (acc_q > SAT_HI)      out_y = SAT_HI;
      else if (acc_q < SAT_LO) out_y = SAT_LO;
      else                     out_y = acc_q;
   end
`else
   assign out_y = acc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dct_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dct_mac_sequencer
// Brief  : Directed + randomized bench with a behavioural Booth-multiplier
//          model and a sum-of-products reference for dct_mac_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dct_mac_sequencer;

   localparam int DW   = 8;
   localparam int NTAP = 8;
   localparam int AW   = 2*DW+3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_x;
   logic [DW-1:0]     in_c;
   logic              mul_clr;
   logic              mul_start;
   logic [DW-1:0]     mul_m;
   logic [DW-1:0]     mul_q;
   logic              mul_done;
   logic [2*DW-1:0]   mul_prod;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     out_y;

   int     errors = 0;
   int     checks = 0;
   int     n_clr = 0, n_start = 0, n_acc = 0, n_ov = 0;
   int     lat = 5;
   longint exp_sum = 0;

   dct_mac_sequencer #(.DW(DW), .NTAP(NTAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_c      (in_c),
      .mul_clr   (mul_clr),
      .mul_start (mul_start),
      .mul_m     (mul_m),
      .mul_q     (mul_q),
      .mul_done  (mul_done),
      .mul_prod  (mul_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y)
   );

   always #5 clk = ~clk;

   // Multiplier model: done rises 'lat' edges after start; the product is
   // taken from the operand buses at completion so unstable operands show up.
   logic mbusy = 1'b0;
   int   mcnt  = 0;
   initial begin
      mul_done = 1'b0;
      mul_prod = '0;
   end
   always @(posedge clk) begin
      if (mul_clr) begin
         mul_done <= 1'b0;
         mbusy    <= 1'b0;
      end else if (mul_start) begin
         mbusy <= 1'b1;
         mcnt  <= lat;
      end else if (mbusy) begin
         if (mcnt <= 1) begin
            mbusy    <= 1'b0;
            mul_done <= 1'b1;
            mul_prod <= 16'($signed(mul_m) * $signed(mul_q));
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   logic ov_prev = 1'b0;
   always @(posedge clk) begin
      if (mul_clr)              n_clr++;
      if (mul_start)            n_start++;
      if (in_valid && in_ready) n_acc++;
      if (out_valid && !ov_prev) n_ov++;
      ov_prev <= out_valid;
   end

   function automatic longint sat(input longint v);
`ifdef DCT_MAC_SAT_EN
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
`endif
      return v;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_pair(input int x, input int c);
      int t = 0;
      in_x     = x[DW-1:0];
      in_c     = c[DW-1:0];
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_wait", longint'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_x     = DW'($urandom);
      in_c     = DW'($urandom);
      exp_sum += longint'(x) * longint'(c);
   endtask

   task automatic get_result(input string tag, input longint exp);
      int t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_valid"}, longint'(out_valid), 1);
      chk(tag, longint'($signed(out_y)), sat(exp));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle"}, longint'(in_ready), 1);
      chk({tag, "_ov_low"}, longint'(out_valid), 0);
      exp_sum = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint held;
      int     acc_before;
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_c = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  longint'(in_ready), 1);
      chk("rst_mul_clr",   longint'(mul_clr), 0);
      chk("rst_mul_start", longint'(mul_start), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_y",     longint'(out_y), 0);
      chk("rst_mul_m",     longint'(mul_m), 0);
      chk("rst_mul_q",     longint'(mul_q), 0);
      rst = 1'b0;
      @(negedge clk);

      // Unit pairs, 5-cycle multiplier
      n_clr = 0; n_start = 0; n_ov = 0; lat = 5;
      for (int i = 0; i < NTAP; i++) send_pair(1, 1);
      get_result("ones", exp_sum);
      chk("ones_clr_cnt",   n_clr, NTAP);
      chk("ones_start_cnt", n_start, NTAP);
      chk("ones_ov_cnt",    n_ov, 1);

      // Most-negative operands: 8 * 16384 = 131072
      lat = 3;
      for (int i = 0; i < NTAP; i++) send_pair(-128, -128);
      get_result("neg_full", 131072);

      // +300 / -200 alternating
      lat = 2;
      for (int i = 0; i < NTAP/2; i++) begin
         send_pair(15, 20);
         send_pair(-10, 20);
      end
      get_result("alt", 400);

      // Backpressure: out_ready low 10 cycles with a pair on offer
      lat = 1;
      for (int i = 0; i < NTAP; i++) send_pair(int'($signed(8'($urandom))), int'($signed(8'($urandom))));
      while (!out_valid) @(negedge clk);
      held       = longint'($signed(out_y));
      acc_before = n_acc;
      in_valid = 1'b1; in_x = 8'd7; in_c = 8'd9;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_x = DW'($urandom);
         in_c = DW'($urandom);
         if (i == 9) begin
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready",  longint'(in_ready), 0);
            chk("bp_out_y",     longint'($signed(out_y)), held);
         end
      end
      chk("bp_no_accept", n_acc, acc_before);
      chk("bp_value", held, sat(exp_sum));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_idle", longint'(in_ready), 1);
      exp_sum = 0;

      // Reset during WAIT of tap 4
      lat = 5;
      for (int i = 0; i < 3; i++) send_pair(100, 100);
      send_pair(50, 50);
      @(negedge clk);
      @(negedge clk);
      chk("mid_wait_done_low", longint'(mul_done), 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready",  longint'(in_ready), 1);
      chk("mid_rst_out_y",     longint'(out_y), 0);
      chk("mid_rst_mul_m",     longint'(mul_m), 0);
      chk("mid_rst_mul_start", longint'(mul_start), 0);
      @(negedge clk);
      rst = 1'b0;
      exp_sum = 0;
      n_clr   = 0;
      @(negedge clk);
      for (int i = 0; i < NTAP; i++) send_pair(3 + i, -7);
      get_result("after_rst", exp_sum);
      chk("after_rst_clr_cnt", n_clr, NTAP);

      // Randomized runs
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NTAP; i++) begin
            lat = int'($urandom_range(1, 6));
            send_pair(int'($signed(8'($urandom))), int'($signed(8'($urandom))));
         end
         get_result($sformatf("rand%0d", r), exp_sum);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
